sha256_w_schedule: RTL and testbench

SHA256_W_SCHEDULE -- requirements
Module: sha256_w_schedule

---
 rtl/sha256_w_schedule_if.sv | 30 +++
 rtl/sha256_w_schedule.sv | 108 ++++++++++
 tb/tb_sha256_w_schedule.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_w_schedule_if.sv
// Handshake bundle between the SHA-256 message block source, the
// schedule expander and the compression rounds.
interface sha256_w_schedule_if #(
   parameter int WK_LENGTH = 64
);
   localparam int IW = $clog2(WK_LENGTH);

   logic          block_valid;
   logic          block_ready;
   logic [511:0]  block_data;
   logic          w_valid;
   logic          w_ready;
   logic [31:0]   w_word;
   logic [31:0]   k_word;
   logic [IW-1:0] w_index;
   logic          w_last;
   logic          busy;

   modport slave (
      input  block_valid, block_data, w_ready,
      output block_ready, w_valid, w_word, k_word,
      output w_index, w_last, busy
   );

   modport master (
      output block_valid, block_data, w_ready,
      input  block_ready, w_valid, w_word, k_word,
      input  w_index, w_last, busy
   );
endinterface

// File: rtl/sha256_w_schedule.sv
// SHA-256 message schedule expander: streams W[0..WK_LENGTH-1] per block.
// Optional K output table: define SHA256_W_SCHEDULE_K_OUT_EN.
module sha256_w_schedule #(
   parameter int WK_LENGTH = 64
) (
   input logic               clock,
   input logic               reset,
   sha256_w_schedule_if.slave bus
);
   localparam int IW = $clog2(WK_LENGTH);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic [31:0]   r_win [16];
   logic [IW-1:0] r_idx;
   logic          w_run;
   logic          w_last;
   logic          w_accept;
   logic          w_hs;
   logic [31:0]   w_new;

   function automatic logic [31:0] f_s0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] f_s1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   assign w_run    = (r_state == S_RUN);
   assign w_last   = w_run && (r_idx == IW'(WK_LENGTH - 1));
   assign w_accept = (r_state == S_IDLE) && bus.block_valid;
   assign w_hs     = w_run && bus.w_ready;
   assign w_new    = f_s1(r_win[14]) + r_win[9]
                   + f_s0(r_win[1]) + r_win[0];

   // State register
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Next state: start on accept, finish on the last word handshake
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE: if (bus.block_valid)        w_next_state = S_RUN;
         S_RUN:  if (bus.w_ready && w_last)  w_next_state = S_IDLE;
         default:                            w_next_state = S_IDLE;
      endcase
   end

   // Word index: restarts at acceptance, steps on every handshake
   always_ff @(posedge clock) begin
      if (reset)         r_idx <= '0;
      else if (w_accept) r_idx <= '0;
      else if (w_hs)     r_idx <= w_last ? '0 : r_idx + IW'(1);
   end

   // 16-word window: load M[0..15], then shift in expanded words
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) r_win[i] <= '0;
      end else if (w_accept) begin
         for (int i = 0; i < 16; i++)
            r_win[i] <= bus.block_data[511 - 32*i -: 32];
      end else if (w_hs) begin
         for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
         r_win[15] <= w_new;
      end
   end

`ifdef SHA256_W_SCHEDULE_K_OUT_EN
   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   assign bus.k_word = w_run ? K_TAB[r_idx] : 32'h0;
`else
   assign bus.k_word = 32'h0;
`endif

   assign bus.block_ready = (r_state == S_IDLE);
   assign bus.busy        = w_run;
   assign bus.w_valid     = w_run;
   assign bus.w_word      = r_win[0];
   assign bus.w_index     = r_idx;
   assign bus.w_last      = w_last;
endmodule

// File: tb/tb_sha256_w_schedule.sv
// Self-checking bench for sha256_w_schedule.
// Reference model expands whole blocks with the textbook recurrence.
module tb_sha256_w_schedule;
   logic clock = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   sha256_w_schedule_if #(.WK_LENGTH(64)) bus ();

   sha256_w_schedule #(.WK_LENGTH(64)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sg0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sg1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Full 64-word expansion, W[t] at bits [t*32 +: 32]
   function automatic logic [2047:0] expand(input logic [511:0] d);
      logic [31:0] w [64];
      logic [2047:0] r;
      for (int t = 0; t < 16; t++) w[t] = d[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++)
         w[t] = sg1(w[t-2]) + w[t-7] + sg0(w[t-15]) + w[t-16];
      for (int t = 0; t < 64; t++) r[t*32 +: 32] = w[t];
      return r;
   endfunction

   // Model state, updated with the inputs the DUT samples at each edge
   logic          chk_en = 1'b0;
   logic          m_run  = 1'b0;
   int            m_t    = 0;
   int            m_hs   = 0;
   int            m_done = 0;
   int            m_acc  = 0;
   logic [2047:0] m_w;
   logic [31:0]   got [64];

   always @(posedge clock) begin
      if (reset) begin
         m_run = 1'b0;
         m_t   = 0;
      end else if (!m_run && bus.block_valid) begin
         m_run = 1'b1;
         m_t   = 0;
         m_hs  = 0;
         m_w   = expand(bus.block_data);
         m_acc++;
      end else if (m_run && bus.w_ready) begin
         m_hs++;
         if (m_t == 63) begin
            m_run = 1'b0;
            m_done++;
         end else begin
            m_t++;
         end
      end
   end

   // Compare process: checks every output on every falling edge
   logic        p_stall = 1'b0;
   logic [31:0] p_word, p_k;
   logic [5:0]  p_idx;
   logic        p_last;

   always @(negedge clock) begin
      if (chk_en) begin
         chk("block_ready", 32'(bus.block_ready), 32'(!m_run));
         chk("busy", 32'(bus.busy), 32'(m_run));
         chk("w_valid", 32'(bus.w_valid), 32'(m_run));
         if (m_run) begin
            chk("w_index", 32'(bus.w_index), 32'(m_t));
            chk("w_word", bus.w_word, m_w[m_t*32 +: 32]);
            chk("w_last", 32'(bus.w_last), 32'(m_t == 63));
            got[m_t] = bus.w_word;
`ifdef SHA256_W_SCHEDULE_K_OUT_EN
            if (m_t == 0)  chk("k0", bus.k_word, 32'h428a2f98);
            if (m_t == 63) chk("k63", bus.k_word, 32'hc67178f2);
`else
            chk("k_word", bus.k_word, 32'h0);
`endif
         end else begin
            chk("w_last_idle", 32'(bus.w_last), 32'h0);
            chk("k_word_idle", bus.k_word, 32'h0);
         end
         if (p_stall) begin
            chk("stall_word", bus.w_word, p_word);
            chk("stall_k", bus.k_word, p_k);
            chk("stall_idx", 32'(bus.w_index), 32'(p_idx));
            chk("stall_last", 32'(bus.w_last), 32'(p_last));
         end
         p_stall = bus.w_valid && !bus.w_ready && !reset;
         p_word  = bus.w_word;
         p_k     = bus.k_word;
         p_idx   = bus.w_index;
         p_last  = bus.w_last;
      end
   end

   task automatic offer(input logic [511:0] d);
      @(posedge clock); #1;
      bus.block_valid = 1'b1;
      bus.block_data  = d;
      @(posedge clock); #1;
      bus.block_valid = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int c;
      c = 0;
      while (m_done < target && c < budget) begin
         @(negedge clock);
         c++;
      end
      chk("done_timeout", 32'(m_done >= target), 32'h1);
   endtask

   logic [511:0]  abc;
   logic [511:0]  blk_b;
   logic [2047:0] pin;
   int            acc0;
   int            c;

   initial begin
      abc = {32'h61626380, {14{32'h0}}, 32'h00000018};
      for (int i = 0; i < 16; i++)
         blk_b[511 - 32*i -: 32] = 32'h9e3779b9 * (i + 3);
      reset           = 1'b1;
      bus.block_valid = 1'b0;
      bus.block_data  = '0;
      bus.w_ready     = 1'b0;

      // Pin the model against hand-derived "abc" words
      pin = expand(abc);
      chk("pin_w0",  pin[0*32 +: 32],  32'h61626380);
      chk("pin_w15", pin[15*32 +: 32], 32'h00000018);
      chk("pin_w16", pin[16*32 +: 32], 32'h61626380);
      chk("pin_w17", pin[17*32 +: 32], 32'h000f0000);
      chk("pin_w18", pin[18*32 +: 32], 32'h7da86405);
      chk("pin_w19", pin[19*32 +: 32], 32'h600003c6);

      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_block_ready", 32'(bus.block_ready), 32'h1);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_w_valid", 32'(bus.w_valid), 32'h0);
      chk("rst_w_last", 32'(bus.w_last), 32'h0);
      chk("rst_w_index", 32'(bus.w_index), 32'h0);
      chk("rst_w_word", bus.w_word, 32'h0);
      chk("rst_k_word", bus.k_word, 32'h0);
      @(posedge clock); #1;
      reset  = 1'b0;
      chk_en = 1'b1;

      // "abc" block at full rate
      bus.w_ready = 1'b1;
      offer(abc);
      wait_done(1, 200);
      chk("hs_full", 32'(m_hs), 32'd64);
      chk("dut_w17", got[17], 32'h000f0000);
      chk("dut_w18", got[18], 32'h7da86405);
      chk("dut_w19", got[19], 32'h600003c6);

      // Same block with random back-pressure and two long stalls
      offer(abc);
      c = 0;
      while (m_done < 2 && c < 600) begin
         @(posedge clock); #1;
         if ((c >= 20 && c < 30) || (c >= 80 && c < 90))
            bus.w_ready = 1'b0;
         else
            bus.w_ready = 1'($urandom_range(0, 1));
         c++;
      end
      chk("stall_timeout", 32'(m_done >= 2), 32'h1);
      chk("hs_stall", 32'(m_hs), 32'd64);
      bus.w_ready = 1'b1;

      // Reset in the middle of a block, then a fresh block
      offer(blk_b);
      c = 0;
      do begin
         @(negedge clock);
         c++;
      end while (!(bus.w_valid && bus.w_index == 6'd30) && c < 200);
      chk("idx30_timeout", 32'(c < 200), 32'h1);
      #1 reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("mid_rst_w_valid", 32'(bus.w_valid), 32'h0);
      chk("mid_rst_ready", 32'(bus.block_ready), 32'h1);
      offer(blk_b);
      wait_done(3, 200);
      chk("hs_after_rst", 32'(m_hs), 32'd64);

      // block_valid held high, data churning while running
      acc0 = m_acc;
      @(posedge clock); #1;
      bus.block_valid = 1'b1;
      bus.block_data  = abc;
      c = 0;
      while (m_done < 5 && c < 400) begin
         @(negedge clock);
         if (m_done >= 5) break;
         #1;
         if (bus.busy)
            for (int i = 0; i < 16; i++)
               bus.block_data[511 - 32*i -: 32] = $urandom();
         c++;
      end
      bus.block_valid = 1'b0;
      chk("hold_timeout", 32'(m_done >= 5), 32'h1);
      chk("hold_accepts", 32'(m_acc - acc0), 32'd2);
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("end_idle", 32'(bus.block_ready), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
